phase_accumulator: RTL and testbench

- NCO phase accumulator for the oscillator path.
- Holds a 32-bit phase register and adds a tuning word to it once per audio sample, using the team's 32-bit full-adder datapath (a = phase, b = tuning word, c_in = 0).
- Consumes the adder's sum and c_out.
- Feeds phase and wrap to the downstream waveform lookup and shaper.
- Also generates the audio sample strobe, accepts tuning words over a valid/ready handshake, and gates the phase on note on/off.

---
 rtl/phase_accumulator.sv | 134 +++++++++++++
 tb/tb_phase_accumulator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_accumulator.sv
// NCO phase accumulator: free-running sample divider, tuning-word handshake, gated phase FSM.
// Latency: phase/wrap/active update one clock after sample_tick; tw_ready drops while a word is pending, until one cycle after the next tick.
module phase_accumulator #(
    parameter int PHASE_W = 32,
    parameter int CLK_DIV = 1042,
    parameter int OUT_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] tw_in,
    input  logic               tw_valid,
    output logic               tw_ready,
    input  logic               gate,
    input  logic               sync,
    output logic               sample_tick,
    output logic [PHASE_W-1:0] phase,
    output logic [OUT_W-1:0]   phase_top,
    output logic               wrap,
    output logic               active
);

    localparam int          CNT_W    = 16;
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic        C_IN     = 1'b0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
    logic               tick_q, tick_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               wrap_q, wrap_d;
    logic               active_q, active_d;
    logic [PHASE_W-1:0] tw_act_q, tw_act_d;
    logic [PHASE_W-1:0] pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;

    // Full-adder datapath: a = phase, b = active tuning word, c_in tied low.
    logic [PHASE_W:0]   add_res;
    logic [PHASE_W-1:0] sum;
    logic               c_out;

    assign add_res = {1'b0, phase_q} + {1'b0, tw_act_q} + {{PHASE_W{1'b0}}, C_IN};
    assign sum     = add_res[PHASE_W-1:0];
    assign c_out   = add_res[PHASE_W];

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 16'd1;
        tick_d    = (div_cnt_q == DIV_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick_q) begin
            case (state_q)
                S_IDLE:  if (gate)  state_d = S_RUN;
                S_RUN:   if (!gate) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Gate drop and sync both force phase to zero; accumulation only in RUN with gate held.
    always_comb begin
        phase_d  = phase_q;
        wrap_d   = 1'b0;
        active_d = active_q;
        if (tick_q) begin
            active_d = (state_d == S_RUN);
            if (state_q == S_RUN && gate && !sync) begin
                phase_d = sum;
                wrap_d  = c_out;
            end else begin
                phase_d = '0;
            end
        end
    end

    // The tick that transfers pending -> active still accumulates with the old word.
    always_comb begin
        tw_act_d   = tw_act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (tick_q && pend_vld_q) begin
            tw_act_d   = pend_q;
            pend_vld_d = 1'b0;
        end
        if (tw_valid && !pend_vld_q) begin
            pend_d     = tw_in;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            tick_q     <= 1'b0;
            phase_q    <= '0;
            wrap_q     <= 1'b0;
            active_q   <= 1'b0;
            tw_act_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            tick_q     <= tick_d;
            phase_q    <= phase_d;
            wrap_q     <= wrap_d;
            active_q   <= active_d;
            tw_act_q   <= tw_act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign tw_ready    = !pend_vld_q;
    assign sample_tick = tick_q;
    assign phase       = phase_q;
    assign phase_top   = phase_q[PHASE_W-1 -: OUT_W];
    assign wrap        = wrap_q;
    assign active      = active_q;

endmodule

// File: tb/tb_phase_accumulator.sv
// Randomized scoreboard bench for phase_accumulator with a cycle-count reference model.
module tb_phase_accumulator;

    localparam int CLK_DIV = 4;
    localparam int LIMIT   = 3 * CLK_DIV + 4;

    logic        clk;
    logic        rst;
    logic [31:0] tw_in;
    logic        tw_valid;
    logic        tw_ready;
    logic        gate;
    logic        sync;
    logic        sample_tick;
    logic [31:0] phase;
    logic [11:0] phase_top;
    logic        wrap;
    logic        active;

    phase_accumulator #(.PHASE_W(32), .CLK_DIV(CLK_DIV), .OUT_W(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .tw_in      (tw_in),
        .tw_valid   (tw_valid),
        .tw_ready   (tw_ready),
        .gate       (gate),
        .sync       (sync),
        .sample_tick(sample_tick),
        .phase      (phase),
        .phase_top  (phase_top),
        .wrap       (wrap),
        .active     (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] ph;
        logic        wr;
        logic        act;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: ticks come from a cycle count since reset release,
    // phase is (prev + word) mod 2^32 with the carry taken from bit 32.
    int unsigned m_cyc    = 0;
    logic [31:0] m_phase  = '0;
    logic [31:0] m_tw     = '0;
    logic [31:0] m_pend   = '0;
    logic        m_pv     = 1'b0;
    logic        m_run    = 1'b0;

    always @(negedge clk) begin
        logic        t;
        logic        pv_old;
        logic        w;
        logic [32:0] s;
        if (rst) begin
            m_cyc   = 0;
            m_phase = '0;
            m_tw    = '0;
            m_pv    = 1'b0;
            m_run   = 1'b0;
            sb_q.push_back('{ph: 32'h0, wr: 1'b0, act: 1'b0});
        end else begin
            t      = (m_cyc != 0) && (m_cyc % CLK_DIV == 0);
            pv_old = m_pv;
            chk("sample_tick", sample_tick, t);
            chk("tw_ready", tw_ready, !pv_old);
            if (t) begin
                w = 1'b0;
                if (!m_run) begin
                    m_run   = gate;
                    m_phase = '0;
                end else if (!gate) begin
                    m_run   = 1'b0;
                    m_phase = '0;
                end else if (sync) begin
                    m_phase = '0;
                end else begin
                    s       = {1'b0, m_phase} + {1'b0, m_tw};
                    m_phase = s[31:0];
                    w       = s[32];
                end
                sb_q.push_back('{ph: m_phase, wr: w, act: m_run});
                if (pv_old) begin
                    m_tw = m_pend;
                    m_pv = 1'b0;
                end
            end
            if (tw_valid && !pv_old) begin
                m_pend = tw_in;
                m_pv   = 1'b1;
            end
            m_cyc++;
        end
    end

    // Monitor: pops one expectation per presented update, checks hold values in between.
    logic prev_rst  = 1'b0;
    logic prev_tick = 1'b0;
    logic have_exp  = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        logic fresh;
        fresh = 1'b0;
        if (prev_rst || prev_tick) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'd0, 64'd1);
            end else begin
                cur      = sb_q.pop_front();
                have_exp = 1'b1;
                fresh    = 1'b1;
            end
        end
        if (have_exp) begin
            chk("phase", phase, cur.ph);
            chk("phase_top", phase_top, cur.ph[31-:12]);
            chk("active", active, cur.act);
            chk("wrap", wrap, fresh ? cur.wr : 1'b0);
        end
        prev_rst  = rst;
        prev_tick = sample_tick;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cycles(n);
        rst = 1'b0;
    endtask

    // Returns just after the edge that ends the next tick cycle.
    task automatic wait_tick();
        int k;
        k = 0;
        while (!sample_tick && k < LIMIT) begin
            cycles(1);
            k++;
        end
        if (k >= LIMIT) chk("tick_timeout", 64'd0, 64'd1);
        cycles(1);
    endtask

    // Leaves tw_valid high so back-to-back sends keep the handshake asserted.
    task automatic send(input logic [31:0] w);
        int k;
        tw_in    = w;
        tw_valid = 1'b1;
        k        = 0;
        while (!tw_ready && k < LIMIT) begin
            cycles(1);
            k++;
        end
        if (k >= LIMIT) chk("send_timeout", 64'd0, 64'd1);
        cycles(1);
    endtask

    initial begin
        logic acc;
        rst      = 1'b1;
        tw_in    = '0;
        tw_valid = 1'b0;
        gate     = 1'b0;
        sync     = 1'b0;

        // Reset and free-running divider
        do_reset(3);
        cycles(14);

        // Basic accumulation with a quarter-turn step and one wrap
        send(32'h4000_0000);
        tw_valid = 1'b0;
        gate     = 1'b1;
        repeat (6) wait_tick();

        // Back-to-back tuning words on a held valid
        send(32'h1234_5678);
        send(32'h0000_FFFF);
        tw_valid = 1'b0;
        repeat (4) wait_tick();

        // Sync beats accumulation, then gate drop returns to IDLE
        gate = 1'b0;
        do_reset(1);
        send(32'h8000_0000);
        tw_valid = 1'b0;
        gate     = 1'b1;
        wait_tick();
        wait_tick();
        chk("half_turn_setup", phase, 32'h8000_0000);
        sync = 1'b1;
        wait_tick();
        sync = 1'b0;
        gate = 1'b0;
        wait_tick();
        cycles(3);

        // Random regression
        do_reset(2);
        gate = 1'b1;
        for (int c = 0; c < 8000; c++) begin
            acc = tw_valid && tw_ready;
            cycles(1);
            if (acc) tw_valid = 1'b0;
            if (!tw_valid && $urandom_range(0, 3) == 0) begin
                tw_valid = 1'b1;
                case ($urandom_range(0, 3))
                    0:       tw_in = '0;
                    1:       tw_in = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                    default: tw_in = $urandom;
                endcase
            end
            sync = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) gate = !gate;
        end
        tw_valid = 1'b0;
        sync     = 1'b0;
        gate     = 1'b0;

        // Mid-operation reset with a word pending
        do_reset(1);
        send(32'hDEAD_BEEF);
        tw_valid = 1'b0;
        gate     = 1'b1;
        wait_tick();
        wait_tick();
        chk("deadbeef_setup", phase, 32'hDEAD_BEEF);
        send(32'h1111_1111);
        tw_valid = 1'b0;
        chk("pending_setup", tw_ready, 1'b0);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        repeat (3) wait_tick();

        gate = 1'b0;
        cycles(2);
        chk("sb_drain", sb_q.size() <= 1, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
